// File: rtl/selecttop_pkg.sv
// selecttop_pkg: shared constants, types and state encoding for the selectTOP6 sequential extractor
package selecttop_pkg;
  localparam int W    = 13;
  localparam int N    = 16;
  localparam int K    = 6;
  localparam int IDXW = 5;
  localparam int CW   = $clog2(N);
  localparam int RW   = (K > 1) ? $clog2(K) : 1;
  localparam int SUMW = W + $clog2(K) + 1;
  typedef logic [W-1:0]    val_t;
  typedef logic [IDXW-1:0] idx_t;
  typedef logic [CW-1:0]   cand_t;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} top_state_e;
  // Source position in the 32-entry matrix: pair number plus which element of the pair won
  function automatic idx_t src_idx(input cand_t c, input logic odd);
    return {c, odd};
  endfunction
endpackage

// File: rtl/masked_argmax16.sv
// masked_argmax16: combinational balanced-tree argmax over unmasked candidates, lowest index wins ties
module masked_argmax16
  import selecttop_pkg::*;
(
  input  val_t         values [0:N-1],
  input  logic [N-1:0] mask,
  output val_t         max_val,
  output cand_t        max_idx,
  output logic         any_valid
);
  // Heap layout: node n has children 2n and 2n+1, leaves at N+i, so left is always the lower index
  val_t  tv [1:2*N-1];
  cand_t ti [1:2*N-1];
  logic  tk [1:2*N-1];
  logic  l;
  always_comb begin
    l = 1'b0;
    for (int i = 0; i < N; i++) begin
      tv[N+i] = values[i];
      ti[N+i] = cand_t'(i);
      tk[N+i] = !mask[i];
    end
    for (int n = N - 1; n >= 1; n--) begin
      l     = tk[2*n] && (!tk[2*n+1] || tv[2*n] >= tv[2*n+1]);
      tv[n] = l ? tv[2*n] : tv[2*n+1];
      ti[n] = l ? ti[2*n] : ti[2*n+1];
      tk[n] = tk[2*n] | tk[2*n+1];
    end
  end
  assign max_val   = tv[1];
  assign max_idx   = ti[1];
  assign any_valid = tk[1];
endmodule

// File: rtl/top6_select_seq.sv
// top6_select_seq: latches 16 pair winners and extracts the top K, one masked argmax per clock.
// Optional TOP6_SUM_EN adds out_sum, the running total of the extracted values.
module top6_select_seq
  import selecttop_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  val_t            in_mat_16 [0:N-1],
  input  logic [N-1:0]    in_sel,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef TOP6_SUM_EN
  output logic [SUMW-1:0] out_sum,
`endif
  output val_t            out_val [0:K-1],
  output idx_t            out_idx [0:K-1]
);
  top_state_e   state, state_n;
  logic [RW-1:0] round;
  logic [N-1:0] mask;
  logic [N-1:0] sel;
  val_t         cand [0:N-1];
  val_t         max_v;
  cand_t        max_i;
  logic         any;
  logic         accept;
  masked_argmax16 u_argmax (
    .values    (cand),
    .mask      (mask),
    .max_val   (max_v),
    .max_idx   (max_i),
    .any_valid (any)
  );
  assign accept    = (state == IDLE) && in_valid;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  always_comb begin
    state_n = accept                                     ? SCAN :
              (state == SCAN && round == RW'(K - 1))     ? DONE :
              (state == DONE && out_ready)               ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  // round saturates at K-1 so it never wraps inside a frame when K is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round <= '0;
      mask  <= '0;
      sel   <= '0;
      for (int i = 0; i < N; i++) cand[i] <= '0;
      for (int k = 0; k < K; k++) begin
        out_val[k] <= '0;
        out_idx[k] <= '0;
      end
    end else if (accept) begin
      round <= '0;
      mask  <= '0;
      sel   <= in_sel;
      cand  <= in_mat_16;
    end else if (state == SCAN && any) begin
      for (int k = 0; k < K; k++)
        if (round == RW'(k)) begin
          out_val[k] <= max_v;
          out_idx[k] <= src_idx(max_i, sel[max_i]);
        end
      mask[max_i] <= 1'b1;
      round       <= (round == RW'(K - 1)) ? round : round + 1'b1;
    end
  end
`ifdef TOP6_SUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          out_sum <= '0;
    else if (accept)                  out_sum <= '0;
    else if (state == SCAN && any)    out_sum <= out_sum + SUMW'(max_v);
  end
`endif
endmodule

// File: tb/tb_top6_select_seq.sv
// tb_top6_select_seq: table-driven frames plus backpressure and asynchronous-reset sequences
module tb_top6_select_seq;
  import selecttop_pkg::*;
  typedef struct packed {
    logic [N-1:0][W-1:0]    vals;
    logic [N-1:0]           sel;
    logic [K-1:0][W-1:0]    ev;
    logic [K-1:0][IDXW-1:0] ei;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid;
  val_t in_mat_16 [0:N-1];
  logic [N-1:0] in_sel = '0;
  val_t out_val [0:K-1];
  idx_t out_idx [0:K-1];
`ifdef TOP6_SUM_EN
  logic [SUMW-1:0] out_sum;
`endif
  vec_t tv [4];
  int checks = 0;
  int errors = 0;
  int lat;
  top6_select_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mat_16 (in_mat_16),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef TOP6_SUM_EN
    .out_sum   (out_sum),
`endif
    .out_val   (out_val),
    .out_idx   (out_idx)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic load(input vec_t v);
    for (int i = 0; i < N; i++) in_mat_16[i] = v.vals[i];
    in_sel = v.sel;
  endtask
  task automatic wait_done(input string name);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, lat, K);
  endtask
  task automatic check_result(input string name, input vec_t v);
    for (int k = 0; k < K; k++) begin
      chk($sformatf("%s val[%0d]", name, k), int'(out_val[k]), int'(v.ev[k]));
      chk($sformatf("%s idx[%0d]", name, k), int'(out_idx[k]), int'(v.ei[k]));
    end
  endtask
  task automatic run_frame(input string name, input vec_t v);
    chk({name, " in_ready"}, int'(in_ready), 1);
    load(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(name);
    check_result(name, v);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " out_valid drop"}, int'(out_valid), 0);
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      tv[0].vals[i] = W'(100 + i);
      tv[1].vals[i] = 13'h1FFF;
      tv[2].vals[i] = '0;
      tv[3].vals[i] = W'(16 - i);
      in_mat_16[i] = '0;
    end
    tv[0].sel = 16'h0000;
    tv[1].sel = 16'hFFFF;
    tv[2].sel = 16'h0020;
    tv[2].vals[5] = 13'd4000;
    tv[2].vals[9] = 13'd4000;
    tv[3].sel = 16'hAAAA;
    for (int k = 0; k < K; k++) begin
      tv[0].ev[k] = W'(115 - k);
      tv[0].ei[k] = IDXW'(30 - 2 * k);
      tv[1].ev[k] = 13'd8191;
      tv[1].ei[k] = IDXW'(2 * k + 1);
      tv[3].ev[k] = W'(16 - k);
    end
    tv[2].ev[0] = 13'd4000; tv[2].ev[1] = 13'd4000;
    tv[2].ev[2] = '0; tv[2].ev[3] = '0; tv[2].ev[4] = '0; tv[2].ev[5] = '0;
    tv[2].ei[0] = 5'd11; tv[2].ei[1] = 5'd18; tv[2].ei[2] = 5'd0;
    tv[2].ei[3] = 5'd2;  tv[2].ei[4] = 5'd4;  tv[2].ei[5] = 5'd6;
    tv[3].ei[0] = 5'd0; tv[3].ei[1] = 5'd3; tv[3].ei[2] = 5'd4;
    tv[3].ei[3] = 5'd7; tv[3].ei[4] = 5'd8; tv[3].ei[5] = 5'd11;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_val0", int'(out_val[0]), 0);
    chk("reset out_idx5", int'(out_idx[5]), 0);
    rst = 1'b0;
    #1;
    chk("reset in_ready", int'(in_ready), 1);
`ifdef TOP6_SUM_EN
    chk("reset out_sum", int'(out_sum), 0);
`endif
    for (int v = 0; v < 4; v++) run_frame($sformatf("vec%0d", v), tv[v]);
    // Backpressure with a second frame waiting on in_valid
    load(tv[0]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    load(tv[3]);
    wait_done("bp first");
`ifdef TOP6_SUM_EN
    chk("sum", int'(out_sum), 675);
`endif
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp out_valid held", int'(out_valid), 1);
      chk("bp in_ready low", int'(in_ready), 0);
      chk("bp val0 held", int'(out_val[0]), 115);
      chk("bp idx5 held", int'(out_idx[5]), 20);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp handshake in_ready", int'(in_ready), 1);
    chk("bp handshake out_valid", int'(out_valid), 0);
    chk("bp retained val0", int'(out_val[0]), 115);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp second accepted", int'(in_ready), 0);
    wait_done("bp second");
    check_result("bp second", tv[3]);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    // Asynchronous reset at round 3
    load(tv[0]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre-reset val0", int'(out_val[0]), 115);
    rst = 1'b1;
    #1;
    chk("async val0", int'(out_val[0]), 0);
    chk("async idx0", int'(out_idx[0]), 0);
    chk("async val2", int'(out_val[2]), 0);
    chk("async out_valid", int'(out_valid), 0);
`ifdef TOP6_SUM_EN
    chk("async out_sum", int'(out_sum), 0);
`endif
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    run_frame("after reset", tv[2]);
    run_frame("after reset2", tv[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
